// File: rtl/regfile_dump_ctrl.sv
// Debug reader for the CPU register file: halts the datapath, walks every
// register through read port 1 and streams each word out with its index.
module regfile_dump_ctrl #(
  parameter int NUM_REGS = 32,
  parameter int ADDR_W   = 5,
  parameter int DATA_W   = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              dump_req_i,
  input  logic              abort_i,
  output logic              stall_o,
  output logic [ADDR_W-1:0] rd_addr_o,
  input  logic [DATA_W-1:0] rd_data_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [DATA_W-1:0] out_data_o,
  output logic [ADDR_W-1:0] out_index_o,
  output logic              out_last_o,
  output logic              done_o
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_READ,
    S_SEND,
    S_DONE
  } state_t;

  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_REGS - 1);

  state_t            r_state;
  logic [ADDR_W-1:0] r_ptr;
  logic [ADDR_W-1:0] w_ptr_next;

  assign w_ptr_next = r_ptr + 1'b1;

  // The only unregistered output: the datapath must freeze the same cycle
  // the FSM leaves IDLE.
  assign stall_o = (r_state != S_IDLE);

  // NOTE: every register here uses <= so all state updates from the same
  // pre-edge values; blocking assignments would leak new values mid-block.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_ptr       <= '0;
      rd_addr_o   <= '0;
      out_valid_o <= 1'b0;
      out_data_o  <= '0;
      out_index_o <= '0;
      out_last_o  <= 1'b0;
      done_o      <= 1'b0;
    end else begin
      done_o <= 1'b0;
      if (abort_i && (r_state != S_IDLE)) begin
        // Abort wins over everything, including a pending handshake.
        r_state     <= S_IDLE;
        out_valid_o <= 1'b0;
        out_last_o  <= 1'b0;
      end else begin
        case (r_state)
          S_IDLE: begin
            if (dump_req_i) begin
              r_ptr     <= '0;
              rd_addr_o <= '0;
              r_state   <= S_READ;
            end
          end
          S_READ: begin
            out_data_o  <= rd_data_i;
            out_index_o <= r_ptr;
            out_last_o  <= (r_ptr == LAST_IDX);
            out_valid_o <= 1'b1;
            r_state     <= S_SEND;
          end
          S_SEND: begin
            if (out_ready_i) begin
              out_valid_o <= 1'b0;
              out_last_o  <= 1'b0;
              if (out_last_o) begin
                r_state <= S_DONE;
              end else begin
                // Pointer only advances below the last index, so it never wraps.
                r_ptr     <= w_ptr_next;
                rd_addr_o <= w_ptr_next;
                r_state   <= S_READ;
              end
            end
          end
          S_DONE: begin
            done_o  <= 1'b1;
            r_state <= S_IDLE;
          end
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_regfile_dump_ctrl.sv
// Directed bench for regfile_dump_ctrl: full dumps, backpressure, ignored
// requests, abort, mid-dump reset, and a 4-register build.
module tb_regfile_dump_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        dump_req;
  logic        abort;
  logic        stall;
  logic [4:0]  rd_addr;
  logic [31:0] rd_data;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic [4:0]  out_index;
  logic        out_last;
  logic        done;

  logic        dump_req4;
  logic        stall4;
  logic [1:0]  rd_addr4;
  logic [31:0] rd_data4;
  logic        out_valid4;
  logic [31:0] out_data4;
  logic [1:0]  out_index4;
  logic        out_last4;
  logic        done4;

  logic [31:0] regs  [32];
  logic [31:0] regs4 [4];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  assign rd_data  = regs[rd_addr];
  assign rd_data4 = regs4[rd_addr4];

  regfile_dump_ctrl #(.NUM_REGS(32), .ADDR_W(5), .DATA_W(32)) dut (
    .clk(clk), .rst_n(rst_n), .dump_req_i(dump_req), .abort_i(abort),
    .stall_o(stall), .rd_addr_o(rd_addr), .rd_data_i(rd_data),
    .out_valid_o(out_valid), .out_ready_i(out_ready), .out_data_o(out_data),
    .out_index_o(out_index), .out_last_o(out_last), .done_o(done)
  );

  regfile_dump_ctrl #(.NUM_REGS(4), .ADDR_W(2), .DATA_W(32)) dut4 (
    .clk(clk), .rst_n(rst_n), .dump_req_i(dump_req4), .abort_i(1'b0),
    .stall_o(stall4), .rd_addr_o(rd_addr4), .rd_data_i(rd_data4),
    .out_valid_o(out_valid4), .out_ready_i(1'b1), .out_data_o(out_data4),
    .out_index_o(out_index4), .out_last_o(out_last4), .done_o(done4)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Pulse a request, then watch the stream at each falling edge until a few
  // cycles past the done pulse. Cycle 1 is the first cycle after the request.
  task automatic run_dump(input int bp_idx, input int bp_len, input int req_idx,
                          output int nwords, output int ndone, output int done_cyc);
    int exp_idx = 0;
    int held = 0;
    int cyc = 1;
    bit req_sent = 0;
    nwords = 0;
    ndone = 0;
    done_cyc = -1;
    @(negedge clk);
    dump_req = 1'b1;
    @(negedge clk);
    dump_req = 1'b0;
    check("lat_stall_n1", stall, 1);
    check("lat_valid_n1", out_valid, 0);
    check("lat_rd_addr", rd_addr, 0);
    while (cyc < 300) begin
      if (cyc == 2) check("lat_valid_n2", out_valid, 1);
      if (done) begin
        ndone++;
        if (done_cyc < 0) done_cyc = cyc;
      end
      out_ready = 1'b1;
      dump_req  = 1'b0;
      if (out_valid) begin
        if ((int'(out_index) == bp_idx) && (held < bp_len)) begin
          out_ready = 1'b0;
          held++;
          check("bp_hold_data", out_data, 32'hA000_0000 + bp_idx);
          check("bp_hold_idx", out_index, bp_idx);
        end else begin
          check("word_idx", out_index, exp_idx);
          check("word_data", out_data, 32'hA000_0000 + exp_idx);
          check("word_last", out_last, (exp_idx == 31));
          exp_idx++;
          nwords++;
        end
        if ((int'(out_index) == req_idx) && !req_sent) begin
          dump_req = 1'b1;
          req_sent = 1'b1;
        end
      end
      if ((done_cyc >= 0) && (cyc >= done_cyc + 4)) break;
      @(negedge clk);
      cyc++;
    end
    check("dump_end_stall", stall, 0);
  endtask

  task automatic wait_for_index(input logic [4:0] idx, input string tag);
    int n = 0;
    while (!(out_valid && (out_index == idx)) && (n < 200)) begin
      @(negedge clk);
      n++;
    end
    check(tag, (out_valid && (out_index == idx)), 1);
  endtask

  task automatic count_done(input int ncyc, output int ndone);
    ndone = 0;
    for (int i = 0; i < ncyc; i++) begin
      @(negedge clk);
      if (done) ndone++;
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int nwords, ndone, done_cyc;
    int w4, d4, dc4, exp4;

    for (int i = 0; i < 32; i++) regs[i] = 32'hA000_0000 + i;
    for (int i = 0; i < 4; i++) regs4[i] = 32'hB000_0000 + i;
    rst_n = 1'b0;
    dump_req = 1'b0;
    dump_req4 = 1'b0;
    abort = 1'b0;
    out_ready = 1'b1;
    repeat (3) @(negedge clk);

    check("rst_stall", stall, 0);
    check("rst_valid", out_valid, 0);
    check("rst_rd_addr", rd_addr, 0);
    check("rst_data", out_data, 0);
    check("rst_index", out_index, 0);
    check("rst_last", out_last, 0);
    check("rst_done", done, 0);
    rst_n = 1'b1;
    @(negedge clk);
    check("idle_stall", stall, 0);

    // 1: full dump, ready high
    run_dump(-1, 0, -1, nwords, ndone, done_cyc);
    check("t1_words", nwords, 32);
    check("t1_done_count", ndone, 1);
    check("t1_done_cycle", done_cyc, 66);

    // 2: five cycles of backpressure on index 7
    run_dump(7, 5, -1, nwords, ndone, done_cyc);
    check("t2_words", nwords, 32);
    check("t2_done_count", ndone, 1);
    check("t2_done_cycle", done_cyc, 71);

    // 3: request during the dump is ignored
    run_dump(-1, 0, 10, nwords, ndone, done_cyc);
    check("t3_words", nwords, 32);
    check("t3_done_count", ndone, 1);
    check("t3_done_cycle", done_cyc, 66);
    count_done(80, ndone);
    check("t3_no_second_dump", ndone, 0);
    check("t3_idle_stall", stall, 0);

    // 4: abort while word 15 is waiting in SEND
    @(negedge clk);
    dump_req = 1'b1;
    @(negedge clk);
    dump_req = 1'b0;
    wait_for_index(5'd15, "t4_reach_idx15");
    abort = 1'b1;
    out_ready = 1'b0;
    @(negedge clk);
    abort = 1'b0;
    out_ready = 1'b1;
    check("t4_abort_valid", out_valid, 0);
    check("t4_abort_stall", stall, 0);
    check("t4_abort_last", out_last, 0);
    check("t4_abort_done", done, 0);
    count_done(80, ndone);
    check("t4_no_done", ndone, 0);
    run_dump(-1, 0, -1, nwords, ndone, done_cyc);
    check("t4_restart_words", nwords, 32);
    check("t4_restart_done", ndone, 1);

    // 5: reset in the middle of a dump
    @(negedge clk);
    dump_req = 1'b1;
    @(negedge clk);
    dump_req = 1'b0;
    wait_for_index(5'd20, "t5_reach_idx20");
    rst_n = 1'b0;
    @(negedge clk);
    check("t5_stall", stall, 0);
    check("t5_valid", out_valid, 0);
    check("t5_rd_addr", rd_addr, 0);
    check("t5_data", out_data, 0);
    check("t5_index", out_index, 0);
    check("t5_last", out_last, 0);
    check("t5_done", done, 0);
    rst_n = 1'b1;
    count_done(80, ndone);
    check("t5_no_done", ndone, 0);
    check("t5_idle_stall", stall, 0);

    // 6: four-register build, ready tied high
    w4 = 0;
    d4 = 0;
    dc4 = -1;
    exp4 = 0;
    @(negedge clk);
    dump_req4 = 1'b1;
    @(negedge clk);
    dump_req4 = 1'b0;
    for (int cyc = 1; cyc <= 20; cyc++) begin
      if (done4) begin
        d4++;
        if (dc4 < 0) dc4 = cyc;
      end
      if (out_valid4) begin
        check("t6_idx", out_index4, exp4);
        check("t6_data", out_data4, 32'hB000_0000 + exp4);
        check("t6_last", out_last4, (exp4 == 3));
        exp4++;
        w4++;
      end
      @(negedge clk);
    end
    check("t6_words", w4, 4);
    check("t6_done_count", d4, 1);
    check("t6_done_cycle", dc4, 10);
    check("t6_idle_stall", stall4, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
